// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared port ids, read-tag type and default widths for the arbiter
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

   localparam int c_addr_w = 17;
   localparam int c_data_w = 8;

   typedef enum logic {
      PORT_HPS = 1'b0,
      PORT_ENG = 1'b1
   } port_e;

   typedef struct packed {
      logic  valid;
      port_e port;
   } rtag_t;

   localparam rtag_t c_tag_none = '{valid: 1'b0, port: PORT_HPS};

endpackage
`default_nettype wire

// File: rtl/mem_arb_rtag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_rtag_pipe
// Brief    : RAM_LAT-deep read-tag shift register; head tag decoded to rvalids
// Revision : 1.0
// ============================================================================
module mem_arb_rtag_pipe
   import mem_arb_pkg::*;
#(
   parameter int RAM_LAT = 2
) (
   input  logic  clk,
   input  logic  reset_n,
   input  rtag_t tag_in,
   output logic  h_rvalid,
   output logic  e_rvalid,
   output logic  any_valid
);

   rtag_t r_stage [RAM_LAT];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RAM_LAT; i++) begin
            r_stage[i] <= c_tag_none;
         end
      end else begin
         r_stage[0] <= tag_in;
         for (int i = 1; i < RAM_LAT; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < RAM_LAT; i++) begin
         any_valid = any_valid | r_stage[i].valid;
      end
   end

   assign h_rvalid = r_stage[RAM_LAT-1].valid && (r_stage[RAM_LAT-1].port == PORT_HPS);
   assign e_rvalid = r_stage[RAM_LAT-1].valid && (r_stage[RAM_LAT-1].port == PORT_ENG);

endmodule
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter
// Brief    : Round-robin HPS/engine arbiter for one single-port RAM
// Revision : 1.0
// ============================================================================
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = c_addr_w,
   parameter int DATA_W  = c_data_w,
   parameter int RAM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              h_req,
   input  logic              h_we,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
   output logic              h_ack,
   output logic              h_rvalid,
   output logic [DATA_W-1:0] h_rdata,
   input  logic              e_req,
   input  logic              e_we,
   input  logic [ADDR_W-1:0] e_addr,
   input  logic [DATA_W-1:0] e_wdata,
   output logic              e_ack,
   output logic              e_rvalid,
   output logic [DATA_W-1:0] e_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   logic              w_h_elig;
   logic              w_e_elig;
   logic              w_grant;
   port_e             w_win;
   logic              w_win_we;
   logic [ADDR_W-1:0] w_win_addr;
   logic [DATA_W-1:0] w_win_wdata;
   logic              w_pipe_busy;
   port_e             r_last_grant;
   logic              r_h_ack;
   logic              r_e_ack;
   rtag_t             r_tag;

   // A port's own ack cycle masks its still-held request.
   always_comb begin
      w_h_elig = h_req & ~r_h_ack;
      w_e_elig = e_req & ~r_e_ack;
      w_grant  = w_h_elig | w_e_elig;
      w_win    = PORT_HPS;
      if (w_h_elig && w_e_elig) begin
         w_win = (r_last_grant == PORT_ENG) ? PORT_HPS : PORT_ENG;
      end else if (w_e_elig) begin
         w_win = PORT_ENG;
      end
   end

   assign w_win_we    = (w_win == PORT_ENG) ? e_we    : h_we;
   assign w_win_addr  = (w_win == PORT_ENG) ? e_addr  : h_addr;
   assign w_win_wdata = (w_win == PORT_ENG) ? e_wdata : h_wdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_h_ack      <= 1'b0;
         r_e_ack      <= 1'b0;
         ram_we       <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         r_tag        <= c_tag_none;
         r_last_grant <= PORT_ENG;
      end else begin
         r_h_ack      <= w_grant && (w_win == PORT_HPS);
         r_e_ack      <= w_grant && (w_win == PORT_ENG);
         ram_we       <= w_grant & w_win_we;
         r_tag.valid  <= w_grant & ~w_win_we;
         r_tag.port   <= w_win;
         if (w_grant) begin
            ram_addr     <= w_win_addr;
            ram_wdata    <= w_win_wdata;
            r_last_grant <= w_win;
         end
      end
   end

   // Registered tag lines up with the registered command; pipe adds RAM_LAT.
   mem_arb_rtag_pipe #(
      .RAM_LAT (RAM_LAT)
   ) u_rtag_pipe (
      .clk       (clk),
      .reset_n   (reset_n),
      .tag_in    (r_tag),
      .h_rvalid  (h_rvalid),
      .e_rvalid  (e_rvalid),
      .any_valid (w_pipe_busy)
   );

   assign h_ack   = r_h_ack;
   assign e_ack   = r_e_ack;
   assign h_rdata = ram_rdata;
   assign e_rdata = ram_rdata;
   assign busy    = r_h_ack | r_e_ack | r_tag.valid | w_pipe_busy;

   a_h_req_held : assert property (@(posedge clk) disable iff (!reset_n)
      (w_h_elig && !(w_grant && w_win == PORT_HPS)) |=> h_req);
   a_e_req_held : assert property (@(posedge clk) disable iff (!reset_n)
      (w_e_elig && !(w_grant && w_win == PORT_ENG)) |=> e_req);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_arbiter
// Brief    : Scoreboard bench for mem_access_arbiter with a 2-cycle RAM model
// Revision : 1.0
// ============================================================================
module tb_mem_access_arbiter;

   localparam int AW  = 17;
   localparam int DW  = 8;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          h_req = 1'b0, h_we = 1'b0;
   logic [AW-1:0] h_addr = '0;
   logic [DW-1:0] h_wdata = '0;
   logic          h_ack, h_rvalid;
   logic [DW-1:0] h_rdata;
   logic          e_req = 1'b0, e_we = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0;
   logic          e_ack, e_rvalid;
   logic [DW-1:0] e_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;
   logic          busy;

   mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_ack(h_ack), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
      .e_ack(e_ack), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: data for the command seen in cycle N appears in N+LAT
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_p [LAT];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      rd_p[0] <= mem[ram_addr];
      for (int i = 1; i < LAT; i++) rd_p[i] <= rd_p[i-1];
   end
   assign ram_rdata = rd_p[LAT-1];

   typedef struct {
      logic          port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            cyc;
   } cmd_t;
   typedef struct {
      logic          port;
      logic [DW-1:0] data;
      int            cyc;
   } rd_t;

   cmd_t q_cmd[$];
   rd_t  q_rd[$];
   int   n_vec = 0;
   int   n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push_cmd(input logic p, input logic we, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d, input int c);
      cmd_t x;
      x.port = p; x.we = we; x.addr = a; x.wdata = d; x.cyc = c;
      q_cmd.push_back(x);
   endfunction

   function automatic void push_rd(input logic p, input logic [DW-1:0] d, input int c);
      rd_t x;
      x.port = p; x.data = d; x.cyc = c;
      q_rd.push_back(x);
   endfunction

   // Monitor: every ack / rvalid is matched against the scoreboard
   always @(negedge clk) begin
      if (reset_n) begin
         if (h_ack && e_ack) chk("both_acks", 32'd1, 32'd0);
         if (h_ack || e_ack) begin
            if (q_cmd.size() == 0) begin
               chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
               cmd_t c;
               c = q_cmd.pop_front();
               chk("ack_port",  {31'd0, e_ack}, {31'd0, c.port});
               chk("ack_cycle", cyc, c.cyc);
               chk("ram_we",    {31'd0, ram_we}, {31'd0, c.we});
               chk("ram_addr",  {15'd0, ram_addr}, {15'd0, c.addr});
               chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, c.wdata});
            end
         end else if (ram_we) begin
            chk("stray_ram_we", 32'd1, 32'd0);
         end
         if (h_rvalid && e_rvalid) chk("both_rvalids", 32'd1, 32'd0);
         if (h_rvalid || e_rvalid) begin
            if (q_rd.size() == 0) begin
               chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
               rd_t r;
               r = q_rd.pop_front();
               chk("rvalid_port",  {31'd0, e_rvalid}, {31'd0, r.port});
               chk("rvalid_cycle", cyc, r.cyc);
               chk("rdata", {24'd0, (e_rvalid ? e_rdata : h_rdata)}, {24'd0, r.data});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ram_addr"},  {15'd0, ram_addr}, 32'd0);
      chk({tag, "_ram_wdata"}, {24'd0, ram_wdata}, 32'd0);
      chk({tag, "_ram_we"},    {31'd0, ram_we}, 32'd0);
      chk({tag, "_acks"},      {30'd0, h_ack, e_ack}, 32'd0);
      chk({tag, "_rvalids"},   {30'd0, h_rvalid, e_rvalid}, 32'd0);
      chk({tag, "_busy"},      {31'd0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      h_req = 1'b0;
      e_req = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Raise one request, wait (bounded) for its ack, drop at the end of the ack cycle
   task automatic request(input logic p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      int k;
      if (p) begin e_we = we; e_addr = a; e_wdata = d; e_req = 1'b1; end
      else   begin h_we = we; h_addr = a; h_wdata = d; h_req = 1'b1; end
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (p ? e_ack : h_ack) break;
      end
      if (k == 20) chk("ack_timeout", 32'd1, 32'd0);
      tick();
      if (p) e_req = 1'b0; else h_req = 1'b0;
   endtask

   initial begin
      int c;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 7);
      mem[17'h00010] = 8'h3C;
      mem[17'h00001] = 8'h11;
      mem[17'h00002] = 8'h22;

      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Single HPS write
      c = cyc;
      push_cmd(1'b0, 1'b1, 17'h1ABCD, 8'h5A, c + 1);
      request(1'b0, 1'b1, 17'h1ABCD, 8'h5A);
      repeat (3) tick();
      @(negedge clk);
      chk("hold_ram_addr", {15'd0, ram_addr}, 32'h1ABCD);
      chk("hold_ram_wdata", {24'd0, ram_wdata}, 32'h5A);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      tick();

      // Single engine read with busy tracking
      c = cyc;
      push_cmd(1'b1, 1'b0, 17'h00010, 8'h00, c + 1);
      push_rd(1'b1, 8'h3C, c + 3);
      e_we = 1'b0; e_addr = 17'h00010; e_wdata = 8'h00; e_req = 1'b1;
      @(negedge clk); chk("rd_busy_c0", {31'd0, busy}, 32'd0);
      tick();
      @(negedge clk); chk("rd_busy_c1", {31'd0, busy}, 32'd1);
      tick();
      e_req = 1'b0;
      @(negedge clk); chk("rd_busy_c2", {31'd0, busy}, 32'd1);
      tick();
      @(negedge clk); chk("rd_busy_c3", {31'd0, busy}, 32'd1);
      tick();
      @(negedge clk); chk("rd_busy_c4", {31'd0, busy}, 32'd0);
      tick();

      // Simultaneous held requests right after reset
      do_reset();
      c = cyc;
      push_cmd(1'b0, 1'b1, 17'h00100, 8'hA1, c + 1);
      push_cmd(1'b1, 1'b1, 17'h00200, 8'hB2, c + 2);
      push_cmd(1'b0, 1'b1, 17'h00100, 8'hA1, c + 3);
      push_cmd(1'b1, 1'b1, 17'h00200, 8'hB2, c + 4);
      h_we = 1'b1; h_addr = 17'h00100; h_wdata = 8'hA1; h_req = 1'b1;
      e_we = 1'b1; e_addr = 17'h00200; e_wdata = 8'hB2; e_req = 1'b1;
      repeat (4) tick();
      h_req = 1'b0;
      tick();
      e_req = 1'b0;
      repeat (3) tick();

      // One port holding req across its ack cycles
      c = cyc;
      push_cmd(1'b0, 1'b1, 17'h00ABC, 8'h77, c + 1);
      push_cmd(1'b0, 1'b1, 17'h00ABC, 8'h77, c + 3);
      push_cmd(1'b0, 1'b1, 17'h00ABC, 8'h77, c + 5);
      h_we = 1'b1; h_addr = 17'h00ABC; h_wdata = 8'h77; h_req = 1'b1;
      repeat (6) tick();
      h_req = 1'b0;
      repeat (3) tick();

      // Interleaved reads HPS then ENG
      c = cyc;
      push_cmd(1'b0, 1'b0, 17'h00001, 8'h00, c + 1);
      push_cmd(1'b1, 1'b0, 17'h00002, 8'h00, c + 2);
      push_rd(1'b0, 8'h11, c + 3);
      push_rd(1'b1, 8'h22, c + 4);
      h_we = 1'b0; h_addr = 17'h00001; h_wdata = 8'h00; h_req = 1'b1;
      tick();
      e_we = 1'b0; e_addr = 17'h00002; e_wdata = 8'h00; e_req = 1'b1;
      tick();
      h_req = 1'b0;
      tick();
      e_req = 1'b0;
      repeat (4) tick();

      // Reset pulsed one cycle after a read grant discards the read
      h_we = 1'b0; h_addr = 17'h00010; h_wdata = 8'h00; h_req = 1'b1;
      tick();
      reset_n = 1'b0;
      h_req = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midop");
      tick();
      reset_n = 1'b1;
      repeat (6) tick();
      c = cyc;
      push_cmd(1'b0, 1'b1, 17'h00333, 8'h01, c + 1);
      push_cmd(1'b1, 1'b1, 17'h00444, 8'h02, c + 2);
      h_we = 1'b1; h_addr = 17'h00333; h_wdata = 8'h01; h_req = 1'b1;
      e_we = 1'b1; e_addr = 17'h00444; e_wdata = 8'h02; e_req = 1'b1;
      tick();
      tick();
      h_req = 1'b0;
      tick();
      e_req = 1'b0;

      for (int k = 0; k < 50; k++) begin
         if (q_cmd.size() == 0 && q_rd.size() == 0) break;
         tick();
      end
      repeat (2) tick();
      chk("sb_cmd_left", q_cmd.size(), 32'd0);
      chk("sb_rd_left", q_rd.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Shares one single-port on-chip pixel/data RAM between two requesters. The HPS side is driven by the PIO registers: address, write data and command strobes. The engine side is the hardware image/processing datapath. The block round-robins grants, registers the RAM command and steers read data back to the owning port through a fixed-latency tag pipeline. It sits between the PIO/engine logic and the RAM macro in the FPGA top level.

## Interface
- ADDR_W, 17, RAM word-address width (matches the PIO address register width)
- DATA_W, 8, RAM data width
- RAM_LAT, 2, RAM read latency in cycles from registered command to ram_rdata valid; legal range 1..4
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- h_req  in  1  HPS request; held until h_ack
- h_we  in  1  HPS write (1) / read (0); stable while h_req
- h_addr  in  ADDR_W  HPS address; stable while h_req
- h_wdata  in  DATA_W  HPS write data; stable while h_req
- h_ack  out  1  one-cycle grant pulse
- h_rvalid  out  1  HPS read data valid pulse
- h_rdata  out  DATA_W  HPS read data, qualified by h_rvalid
- e_req, e_we, e_addr, e_wdata  in  1/1/ADDR_W/DATA_W  engine request, same rules as HPS
- e_ack, e_rvalid  out  1  engine grant / read-valid pulses
- e_rdata  out  DATA_W  engine read data, qualified by e_rvalid
- ram_addr  out  ADDR_W  registered RAM address
- ram_wdata  out  DATA_W  registered RAM write data
- ram_we  out  1  registered RAM write enable, one-cycle pulse
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  high while any read is in flight or any ack is high

## Operation
- Eligibility in cycle N: port eligible = req & ~ack (a port's own ack cycle masks its still-high req, preventing a double grant).
- Arbitration: one eligible port → grant it. Both eligible → grant the port not granted most recently (last_grant pointer). Pointer updates only on a grant.
- Reset value of last_grant = ENG, so HPS wins the first contention after reset.
- Grant at edge ending cycle N registers ram_addr/ram_wdata/ram_we from the winner and raises winner ack in cycle N+1.
- Writes: ram_we=1 for exactly cycle N+1; no read return.
- Reads: ram_we=0 in N+1. A tag {valid, port} enters the RAM_LAT-deep pipeline. In cycle N+1+RAM_LAT the tagged port's rvalid=1; the other port's rvalid=0.
- h_rdata and e_rdata are both direct copies of ram_rdata. Their value is meaningful only when the matching rvalid is high.
- No grant cycle: ram_we=0; ram_addr and ram_wdata hold their last values; no tag is inserted.
- Addresses are used unmodified; no wrap or range check (full 2^ADDR_W space).

## Timing
- Reset values: ram_addr=0, ram_wdata=0, ram_we=0, h_ack=e_ack=0, h_rvalid=e_rvalid=0, busy=0, tag pipeline all invalid, last_grant=ENG.
- Request to ack: 1 cycle (req first high in N, granted, ack in N+1) when the port wins. A losing port waits; under round robin its worst-case wait is 1 extra grant.
- Read latency, req to rvalid: 1+RAM_LAT cycles when uncontended; 3 cycles at RAM_LAT=2.
- Throughput: one RAM access per cycle when both ports alternate; at most one per 2 cycles for a single port (ack-mask rule).
- Requester rule: req/we/addr/wdata must stay stable from assertion through the ack cycle. The requester drops req or presents a new request at the edge ending the ack cycle.
- Dropping req before ack is illegal; behaviour is undefined and flagged by an assertion.
- Reset mid-operation: all tags are cleared and in-flight reads are discarded (no rvalid after reset release). Outputs go to their reset values asynchronously.
- Back-to-back reads from alternating ports return in grant order, one rvalid per cycle, never both rvalids in the same cycle.

## Structure
- Package mem_arb_pkg: port-id enum (PORT_HPS=0, PORT_ENG=1), read-tag struct {valid, port}, default ADDR_W/DATA_W constants shared with the PIO/engine top level.
- Sub-module mem_arb_rtag_pipe: RAM_LAT-deep shift register of tags with async reset. Outputs the head tag, decoded to h_rvalid/e_rvalid.
- Top level holds the eligibility mask, round-robin pointer, registered RAM command and busy logic.

## Test plan
- Single HPS write: h_req=1, h_we=1, h_addr=0x1ABCD, h_wdata=0x5A → h_ack and ram_we high in cycle 2, ram_addr=0x1ABCD, ram_wdata=0x5A, no rvalid.
- Single engine read, RAM_LAT=2: e_addr=0x00010, RAM model holds 0x3C → e_ack in cycle 2, e_rvalid=1 with e_rdata=0x3C in cycle 4, h_rvalid stays 0.
- Simultaneous requests right after reset, both held continuously → grant order HPS, ENG, HPS, ENG; ram_addr alternates every cycle; acks never overlap.
- Held req across the ack cycle: h_req kept high with the same address → exactly one grant per 2 cycles and no duplicate ram_we in the ack cycle.
- Interleaved reads HPS addr 0x00001 (data 0x11) then ENG addr 0x00002 (data 0x22) → h_rvalid/0x11 then e_rvalid/0x22 on consecutive cycles.
- reset_n pulsed low one cycle after a read grant → no rvalid ever appears for that read; all outputs are 0 during reset; the next contention is won by HPS.
